uart_tx_fifo: RTL and testbench

Buffered UART transmitter: fabric logic pushes bytes into an internal FIFO and the block serializes them onto the TX line as 8N1 frames, back-to-back, with no per-byte handshake from the writer. It is the transmit-side counterpart of the receive-and-buffer path in the echo design. It replaces bare uart_tx instantiations wherever a producer emits bursts faster than the line rate.

---
 rtl/uart_tx_fifo_if.sv | 31 +++
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the buffered UART transmitter.
// The producer (master) pushes bytes and watches FIFO status.
// The transmitter (slave) accepts bytes and reports status.
interface uart_tx_fifo_if #(
    parameter int FIFO_ADDR_W = 2
);
    logic                   i_Wr_En;
    logic [7:0]             i_Wr_Byte;
    logic                   o_Full;
    logic                   o_Empty;
    logic [FIFO_ADDR_W:0]   o_Count;
    logic                   o_Overflow;

    modport master (
        output i_Wr_En,
        output i_Wr_Byte,
        input  o_Full,
        input  o_Empty,
        input  o_Count,
        input  o_Overflow
    );

    modport slave (
        input  i_Wr_En,
        input  i_Wr_Byte,
        output o_Full,
        output o_Empty,
        output o_Count,
        output o_Overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes pushed into a small FIFO are serialized
// as back-to-back 8N1 frames, LSB first. Frames are separated by exactly one
// IDLE cycle, in which the next byte is popped.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_ADDR_W  = 2
) (
    input  logic          i_Clock,
    input  logic          i_Rst_n,
    uart_tx_fifo_if.slave wr_if,
    output logic          o_Tx_Serial,
    output logic          o_Tx_Active,
    output logic          o_Tx_Done
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_ADDR_W:0] DEPTH_C  = (FIFO_ADDR_W + 1)'(DEPTH);
    localparam logic [FIFO_ADDR_W:0] CNT_ONE  = (FIFO_ADDR_W + 1)'(1);
    localparam logic [FIFO_ADDR_W-1:0] PTR_ONE = FIFO_ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]             mem_q [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_W:0]   count_q, count_d;
    logic                   overflow_q;
    logic                   wr_accept;
    logic                   pop;

    state_t                 state_q;
    logic [CNT_W-1:0]       clk_cnt_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic                   tx_serial_q;
    logic                   tx_active_q;
    logic                   tx_done_q;

    // A write while full is dropped even if a pop happens on the same edge.
    assign wr_accept = wr_if.i_Wr_En && (count_q != DEPTH_C);
    assign pop       = (state_q == IDLE) && (count_q != '0);

    // Next-state for FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO bookkeeping registers and the overflow pulse.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= wr_if.i_Wr_En && (count_q == DEPTH_C);
        end
    end

    // FIFO storage; stale entries are never read, so no reset is needed.
    always_ff @(posedge i_Clock) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_if.i_Wr_Byte;
        end
    end

    // Transmit FSM with registered line, active and done outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_serial_q <= 1'b1;
                    clk_cnt_q   <= '0;
                    bit_idx_q   <= '0;
                    if (pop) begin
                        shift_q     <= mem_q[rd_ptr_q];
                        state_q     <= START;
                        tx_serial_q <= 1'b0;
                        tx_active_q <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q   <= '0;
                        state_q     <= DATA;
                        tx_serial_q <= shift_q[0];
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q     <= STOP;
                            tx_serial_q <= 1'b1;
                        end else begin
                            bit_idx_q   <= bit_idx_q + 3'd1;
                            shift_q     <= {1'b0, shift_q[7:1]};
                            tx_serial_q <= shift_q[1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q   <= '0;
                        state_q     <= IDLE;
                        tx_active_q <= 1'b0;
                        tx_done_q   <= 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_if.o_Count    = count_q;
    assign wr_if.o_Empty    = (count_q == '0);
    assign wr_if.o_Full     = (count_q == DEPTH_C);
    assign wr_if.o_Overflow = overflow_q;
    assign o_Tx_Serial      = tx_serial_q;
    assign o_Tx_Active      = tx_active_q;
    assign o_Tx_Done        = tx_done_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for the buffered UART transmitter with a line monitor
// that decodes 8N1 frames by sampling mid-bit.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CPB = 104;
    localparam int AW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_serial, tx_active, tx_done;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo_if #(.FIFO_ADDR_W(AW)) wr_if ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_W(AW)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .wr_if       (wr_if),
        .o_Tx_Serial (tx_serial),
        .o_Tx_Active (tx_active),
        .o_Tx_Done   (tx_done)
    );

    always #5 clk = ~clk;

    // Line monitor state
    int unsigned cyc = 0;
    bit          mon_busy = 1'b0;
    int          mon_ph = 0;
    int          mon_n = 0;
    int unsigned mon_start = 0;
    logic [7:0]  mon_sh = '0;
    logic [7:0]  rx_q[$];
    int unsigned rx_t[$];
    int          frame_err = 0;
    int          done_cnt = 0;
    int          ovf_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else begin
            if (tx_done === 1'b1) done_cnt++;
            if (wr_if.o_Overflow === 1'b1) ovf_cnt++;
            if (!mon_busy) begin
                if (tx_serial === 1'b0) begin
                    mon_busy  = 1'b1;
                    mon_ph    = 0;
                    mon_start = cyc;
                end
            end else begin
                mon_ph++;
            end
            if (mon_busy && (mon_ph % CPB) == CPB / 2) begin
                mon_n = mon_ph / CPB;
                if (mon_n == 0) begin
                    if (tx_serial !== 1'b0) frame_err++;
                end else if (mon_n <= 8) begin
                    mon_sh[mon_n-1] = tx_serial;
                end else begin
                    if (tx_serial !== 1'b1) frame_err++;
                    rx_q.push_back(mon_sh);
                    rx_t.push_back(mon_start);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_monitor();
        rx_q.delete();
        rx_t.delete();
        frame_err = 0;
        done_cnt  = 0;
        ovf_cnt   = 0;
    endtask

    task automatic run_until_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (wr_if.o_Empty === 1'b1 && tx_active === 1'b0 && !mon_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_if.i_Wr_En   = i[0];
            wr_if.i_Wr_Byte = 8'(i * 17);
            tick();
            total++;
            if (tx_serial !== 1'b1 || wr_if.o_Count !== 3'd0 || wr_if.o_Empty !== 1'b1 ||
                tx_done !== 1'b0 || wr_if.o_Overflow !== 1'b0 || tx_active !== 1'b0 ||
                wr_if.o_Full !== 1'b0) begin
                bad++;
                $display("FAIL reset_state cyc%0d: got ser=%b cnt=%0d emp=%b done=%b ovf=%b act=%b full=%b expected 1 0 1 0 0 0 0",
                         i, tx_serial, wr_if.o_Count, wr_if.o_Empty, tx_done, wr_if.o_Overflow, tx_active, wr_if.o_Full);
            end
        end
        wr_if.i_Wr_En = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (tx_serial !== 1'b1 || wr_if.o_Count !== 3'd0) begin
            bad++;
            $display("FAIL reset_release: got ser=%b cnt=%0d expected ser=1 cnt=0", tx_serial, wr_if.o_Count);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        int errs;
        frame = {1'b1, 8'h55, 1'b0};
        clear_monitor();
        wr_if.i_Wr_En = 1'b1; wr_if.i_Wr_Byte = 8'h55;
        tick();
        wr_if.i_Wr_En = 1'b0;
        total++;
        if (wr_if.o_Count !== 3'd1 || tx_serial !== 1'b1 || tx_active !== 1'b0) begin
            bad++;
            $display("FAIL single_after_write: got cnt=%0d ser=%b act=%b expected 1 1 0", wr_if.o_Count, tx_serial, tx_active);
        end
        tick();
        total++;
        if (tx_serial !== 1'b0 || tx_active !== 1'b1 || wr_if.o_Empty !== 1'b1) begin
            bad++;
            $display("FAIL single_start_edge: got ser=%b act=%b emp=%b expected 0 1 1", tx_serial, tx_active, wr_if.o_Empty);
        end
        for (int lvl = 0; lvl < 10; lvl++) begin
            errs = 0;
            for (int c = 0; c < CPB; c++) begin
                if (tx_serial !== frame[lvl] || tx_active !== 1'b1 || tx_done !== 1'b0) errs++;
                tick();
            end
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL single_level%0d: got %0d wrong cycles expected 0 (level %b)", lvl, errs, frame[lvl]);
            end
        end
        total++;
        if (tx_done !== 1'b1 || tx_active !== 1'b0 || tx_serial !== 1'b1) begin
            bad++;
            $display("FAIL single_done_pulse: got done=%b act=%b ser=%b expected 1 0 1", tx_done, tx_active, tx_serial);
        end
        tick();
        total++;
        if (tx_done !== 1'b0 || wr_if.o_Empty !== 1'b1) begin
            bad++;
            $display("FAIL single_done_end: got done=%b emp=%b expected 0 1", tx_done, wr_if.o_Empty);
        end
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55 || done_cnt != 1 || frame_err != 0) begin
            bad++;
            $display("FAIL single_rx: got n=%0d b=%h done=%0d ferr=%0d expected 1 55 1 0",
                     rx_q.size(), rx_q[0], done_cnt, frame_err);
        end
    endtask

    task automatic test_burst();
        logic [7:0] b [4];
        bit ok;
        b = '{8'h41, 8'h42, 8'h43, 8'h44};
        clear_monitor();
        for (int i = 0; i < 4; i++) begin
            wr_if.i_Wr_En = 1'b1; wr_if.i_Wr_Byte = b[i];
            tick();
        end
        wr_if.i_Wr_En = 1'b0;
        // first byte was popped on the edge of the second write
        total++;
        if (wr_if.o_Count !== 3'd3 || wr_if.o_Full !== 1'b0) begin
            bad++;
            $display("FAIL burst_count: got cnt=%0d full=%b expected 3 0", wr_if.o_Count, wr_if.o_Full);
        end
        run_until_idle(6000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL burst_timeout: got busy expected idle within budget");
        end
        total++;
        if (done_cnt != 4 || rx_q.size() != 4 || frame_err != 0) begin
            bad++;
            $display("FAIL burst_frames: got done=%0d n=%0d ferr=%0d expected 4 4 0", done_cnt, rx_q.size(), frame_err);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rx_q[i] !== b[i]) begin
                bad++;
                $display("FAIL burst_byte%0d: got %h expected %h", i, rx_q[i], b[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rx_t[i+1] - rx_t[i] != 1041) begin
                bad++;
                $display("FAIL burst_spacing%0d: got %0d expected 1041", i, rx_t[i+1] - rx_t[i]);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_monitor();
        for (int i = 0; i < 5; i++) begin
            wr_if.i_Wr_En = 1'b1; wr_if.i_Wr_Byte = 8'(8'h10 + i);
            tick();
        end
        total++;
        if (wr_if.o_Count !== 3'd4 || wr_if.o_Full !== 1'b1 || wr_if.o_Overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_full: got cnt=%0d full=%b ovf=%b expected 4 1 0", wr_if.o_Count, wr_if.o_Full, wr_if.o_Overflow);
        end
        wr_if.i_Wr_Byte = 8'hFF;
        tick();
        wr_if.i_Wr_En = 1'b0;
        total++;
        if (wr_if.o_Overflow !== 1'b1 || wr_if.o_Count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_pulse: got ovf=%b cnt=%0d expected 1 4", wr_if.o_Overflow, wr_if.o_Count);
        end
        tick();
        total++;
        if (wr_if.o_Overflow !== 1'b0 || wr_if.o_Count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_pulse_end: got ovf=%b cnt=%0d expected 0 4", wr_if.o_Overflow, wr_if.o_Count);
        end
        run_until_idle(7000, ok);
        total++;
        if (!ok || done_cnt != 5 || ovf_cnt != 1 || rx_q.size() != 5 || frame_err != 0) begin
            bad++;
            $display("FAIL ovf_frames: got ok=%b done=%0d ovfs=%0d n=%0d ferr=%0d expected 1 5 1 5 0",
                     ok, done_cnt, ovf_cnt, rx_q.size(), frame_err);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rx_q[i] !== 8'(8'h10 + i)) begin
                bad++;
                $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_q[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_monitor();
        for (int i = 0; i < 10; i++) begin
            wr_if.i_Wr_En = 1'b1; wr_if.i_Wr_Byte = 8'(i);
            tick();
            wr_if.i_Wr_En = 1'b0;
            for (int c = 0; c < 1100; c++) tick();
        end
        for (int i = 10; i < 14; i++) begin
            wr_if.i_Wr_En = 1'b1; wr_if.i_Wr_Byte = 8'(i);
            tick();
        end
        wr_if.i_Wr_En = 1'b0;
        run_until_idle(6000, ok);
        total++;
        if (!ok || rx_q.size() != 14 || done_cnt != 14 || frame_err != 0) begin
            bad++;
            $display("FAIL wrap_frames: got ok=%b n=%0d done=%0d ferr=%0d expected 1 14 14 0",
                     ok, rx_q.size(), done_cnt, frame_err);
        end
        for (int i = 0; i < 14; i++) begin
            total++;
            if (rx_q[i] !== 8'(i)) begin
                bad++;
                $display("FAIL wrap_byte%0d: got %h expected %h", i, rx_q[i], 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        clear_monitor();
        wr_if.i_Wr_En = 1'b1; wr_if.i_Wr_Byte = 8'hA5; tick();
        wr_if.i_Wr_Byte = 8'h01; tick();
        wr_if.i_Wr_Byte = 8'h02; tick();
        wr_if.i_Wr_En = 1'b0;
        // now one cycle into the start bit; move to the middle of data bit 3
        for (int c = 0; c < 4 * CPB + 49; c++) tick();
        total++;
        if (tx_serial !== 1'b0 || tx_active !== 1'b1 || wr_if.o_Count !== 3'd2) begin
            bad++;
            $display("FAIL midrst_pre: got ser=%b act=%b cnt=%0d expected 0 1 2", tx_serial, tx_active, wr_if.o_Count);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (tx_serial !== 1'b1 || wr_if.o_Count !== 3'd0 || tx_active !== 1'b0 || wr_if.o_Empty !== 1'b1) begin
            bad++;
            $display("FAIL midrst_async: got ser=%b cnt=%0d act=%b emp=%b expected 1 0 0 1",
                     tx_serial, wr_if.o_Count, tx_active, wr_if.o_Empty);
        end
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 2000; c++) begin
            if (tx_serial !== 1'b1 || tx_active !== 1'b0) lows++;
            tick();
        end
        total++;
        if (lows != 0 || done_cnt != 0 || rx_q.size() != 0 || wr_if.o_Empty !== 1'b1) begin
            bad++;
            $display("FAIL midrst_after: got busy_cycles=%0d done=%0d n=%0d emp=%b expected 0 0 0 1",
                     lows, done_cnt, rx_q.size(), wr_if.o_Empty);
        end
    endtask

    initial begin
        wr_if.i_Wr_En   = 1'b0;
        wr_if.i_Wr_Byte = '0;
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_wrap();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end
endmodule
